// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
package imem_pkg;

   localparam int unsigned IMEM_DEPTH  = 64;
   localparam int unsigned IMEM_ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FILL = 2'd2,
      RUN  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// Writable instruction RAM: synchronous write, combinational read.
module imem_ram #(
   parameter int unsigned N      = 32,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [N-1:0]      wdata_i,
   output logic [N-1:0]      rdata_o
);

   logic [N-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/imem_loader.sv
// Boot sequencer: streams a program into the instruction RAM, zero-fills the
// rest, then releases the CPU and hands the RAM read port to the fetch path.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned N      = 32,
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DEPTH  = IMEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [N-1:0]      in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [N-1:0]      fetch_q,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [N-1:0]      mem_wdata,
   input  logic [N-1:0]      mem_rdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count
);

   localparam int unsigned       CNT_W     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              done_q, done_d;

   // State and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   // Next state and RAM/CPU muxing; wr_ptr never wraps past the last word
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      done_d    = 1'b0;
      cpu_hold  = 1'b1;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = wr_ptr_q;
      mem_wdata = '0;
      fetch_q   = '0;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d  = LOAD;
               wr_ptr_d = '0;
               count_d  = '0;
            end
         end
         LOAD: begin
            in_ready  = 1'b1;
            mem_we    = in_valid;
            mem_wdata = in_data;
            if (in_valid) begin
               count_d = count_q + CNT_W'(1);
               if (wr_ptr_q == LAST_ADDR) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end else begin
                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                  if (in_last) state_d = FILL;
               end
            end
         end
         FILL: begin
            mem_we = 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
               state_d = RUN;
               done_d  = 1'b1;
            end else begin
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
         end
         RUN: begin
            cpu_hold = 1'b0;
            mem_addr = fetch_addr;
            fetch_q  = mem_rdata;
            if (load_start) begin
               state_d  = LOAD;
               wr_ptr_d = '0;
               count_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign load_done  = done_q;
   assign load_count = count_q;

endmodule
